// File: rtl/pixel_sram_pkg.sv
// Shared constants, types and window helper for the pixel SRAM arbiter.
// All timing compares are unsigned; h positions carry one extra bit so look-ahead never wraps.
package pixel_sram_pkg;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int WR_CYCLES  = 3;

  localparam logic [CNT_W:0]   H_WIN_START = 13'd157;
  localparam logic [CNT_W:0]   H_WIN_END   = 13'd800;
  localparam logic [CNT_W-1:0] V_WIN_START = 12'd45;
  localparam logic [CNT_W-1:0] V_WIN_END   = 12'd525;

  typedef enum logic [2:0] {
    IDLE,
    GPU_RD,
    W_SETUP,
    W_PULSE,
    W_HOLD
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  // True when the pixel engine owns the SRAM at line position h of line v.
  function automatic logic in_gpu_win(input logic [CNT_W:0]   h,
                                      input logic [CNT_W-1:0] v,
                                      input logic             using_lb);
    return !using_lb && (v >= V_WIN_START) && (v < V_WIN_END) &&
           (h >= H_WIN_START) && (h < H_WIN_END);
  endfunction

endpackage

// File: rtl/pixel_wr_fifo.sv
// Synchronous FIFO buffering CPU framebuffer writes; head is visible combinationally.
// Push while full and pop while empty are ignored; simultaneous push/pop keeps the count.
module pixel_wr_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                         clkPixel,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity, and leaving it out lets it map to RAM.
  always_ff @(posedge clkPixel) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clkPixel or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_sram_arbiter.sv
// Owns the 8-bit async pixel SRAM: pixel-engine reads inside the read window,
// queued CPU writes (SETUP/PULSE/HOLD) everywhere else, never started too close to the window.
module pixel_sram_arbiter
  import pixel_sram_pkg::*;
(
  input  logic               clkPixel,
  input  logic               resetn,
  input  logic [CNT_W-1:0]   h_count,
  input  logic [CNT_W-1:0]   v_count,
  input  logic               vsync,
  input  logic               blank,
  input  logic [ADDR_W-1:0]  gpu_addr,
  output logic [DATA_W-1:0]  gpu_data,
  input  logic               gpu_using_lb,
  input  logic               cpu_wr_valid,
  output logic               cpu_wr_ready,
  input  logic [ADDR_W-1:0]  cpu_wr_addr,
  input  logic [DATA_W-1:0]  cpu_wr_data,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [ADDR_W-1:0]  sram_addr,
  input  logic [DATA_W-1:0]  sram_dq_in,
  output logic [DATA_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  arb_state_t state;
  logic       ready_en;
  logic       gpu_win;
  logic       win_soon;
  logic       start_write;
  logic       fifo_full;
  logic       fifo_empty;
  wr_entry_t  push_entry;
  wr_entry_t  head;

  // Sync and blank are informational only at this level.
  logic unused_inputs;
  assign unused_inputs = ^{vsync, blank};

  assign gpu_win = in_gpu_win({1'b0, h_count}, v_count, gpu_using_lb);

  // A write needs the next WR_CYCLES positions of this line clear of the read window.
  always_comb begin
    // NOTE: default first so no path leaves the variable unassigned and a latch is inferred.
    win_soon = 1'b0;
    for (int i = 1; i <= WR_CYCLES; i++) begin
      win_soon = win_soon | in_gpu_win({1'b0, h_count} + 13'(i), v_count, gpu_using_lb);
    end
  end

  assign cpu_wr_ready = ready_en && !fifo_full;
  assign push_entry   = '{addr: cpu_wr_addr, data: cpu_wr_data};
  assign start_write  = (state == IDLE) && !gpu_win && !fifo_empty && !win_soon;

  pixel_wr_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clkPixel  (clkPixel),
    .resetn    (resetn),
    .push      (cpu_wr_valid && cpu_wr_ready),
    .push_data (push_entry),
    .pop       (start_write),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clkPixel or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ready_en    <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      gpu_data    <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (gpu_win) begin
            state     <= GPU_RD;
            sram_addr <= gpu_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
          end else if (start_write) begin
            state       <= W_SETUP;
            sram_addr   <= head.addr;
            sram_dq_out <= head.data;
            sram_dq_oe  <= 1'b1;
            sram_ce_n   <= 1'b0;
            sram_we_n   <= 1'b1;
          end
        end
        GPU_RD: begin
          // Data for the address presented one edge earlier.
          gpu_data <= sram_dq_in;
          if (gpu_win) begin
            sram_addr <= gpu_addr;
          end else begin
            state     <= IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
          end
        end
        W_SETUP: begin
          state     <= W_PULSE;
          sram_we_n <= 1'b0;
        end
        W_PULSE: begin
          state     <= W_HOLD;
          sram_we_n <= 1'b1;
        end
        W_HOLD: begin
          state      <= IDLE;
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sram_arbiter.sv
// Randomized bench for pixel_sram_arbiter with a queue/counter reference model and an SRAM model.
module tb_pixel_sram_arbiter;

  localparam int HS = 157, HE = 800, VS = 45, VE = 525, H_TOTAL = 800, V_TOTAL = 525;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clkPixel, resetn;
  logic [11:0] h_count, v_count;
  logic        vsync, blank, gpu_using_lb;
  logic [16:0] gpu_addr, cpu_wr_addr, sram_addr;
  logic [7:0]  gpu_data, cpu_wr_data, sram_dq_in, sram_dq_out;
  logic        cpu_wr_valid, cpu_wr_ready, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [4:0]  fifo_level;

  pixel_sram_arbiter dut (
    .clkPixel(clkPixel), .resetn(resetn), .h_count(h_count), .v_count(v_count),
    .vsync(vsync), .blank(blank), .gpu_addr(gpu_addr), .gpu_data(gpu_data),
    .gpu_using_lb(gpu_using_lb), .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .fifo_level(fifo_level),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  initial clkPixel = 1'b0;
  always #20 clkPixel = ~clkPixel;

  // Physical SRAM seen through the pins, and the reference memory built from accepted writes.
  logic [7:0] sram_mem [131072];
  logic [7:0] ref_mem  [131072];

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'h00;

  always @(posedge clkPixel) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end

  int n_checks = 0, n_errors = 0;
  int pulse_cnt = 0, rd_cycles = 0;
  logic [16:0] last_addr;
  logic [7:0]  last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t h=%0d v=%0d)", tag, got, exp, $time, h_count, v_count);
    end
  endtask

  always @(negedge clkPixel) begin
    if (resetn) begin
      if (!sram_we_n) begin
        pulse_cnt++;
        last_addr = sram_addr;
        last_data = sram_dq_out;
      end
      if (!sram_oe_n) rd_cycles++;
      check("bus_conflict", 32'(!sram_oe_n && sram_dq_oe), 0);
    end
  end

  // Reference model: write queue, busy countdown for a write in flight, read-ownership flag.
  wr_t         mq[$];
  wr_t         send_q[$];
  wr_t         m_cur;
  int          m_busy;
  bit          m_reading, m_ready_en, rand_gpu;
  logic [16:0] m_rd_addr;
  logic [7:0]  m_exp_gpu;

  function automatic bit ref_win(input int h, input int v, input bit lb);
    return !lb && v >= VS && v < VE && h >= HS && h < HE;
  endfunction

  function automatic bit ref_soon(input int h, input int v, input bit lb);
    for (int i = 1; i <= 3; i++) if (ref_win(h + i, v, lb)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_idle();
    return mq.size() == 0 && send_q.size() == 0 && m_busy == 0 && !m_reading;
  endfunction

  task automatic model_reset();
    mq.delete();
    send_q.delete();
    m_busy = 0; m_reading = 1'b0; m_ready_en = 1'b0; m_exp_gpu = 8'h00; m_rd_addr = '0;
  endtask

  task automatic drive_cpu();
    cpu_wr_valid = send_q.size() > 0;
    if (send_q.size() > 0) begin
      cpu_wr_addr = send_q[0].a;
      cpu_wr_data = send_q[0].d;
    end
  endtask

  task automatic set_pos(input int h, input int v);
    h_count = 12'(h);
    v_count = 12'(v);
    vsync   = v < 2;
    blank   = !(v >= VS && v < VE && h >= 160);
  endtask

  task automatic tick();
    bit          win_c, soon_c, acc;
    logic [16:0] ga_c;
    win_c  = ref_win(h_count, v_count, gpu_using_lb);
    soon_c = ref_soon(h_count, v_count, gpu_using_lb);
    ga_c   = gpu_addr;
    acc    = cpu_wr_valid && m_ready_en && (mq.size() < 16);
    @(posedge clkPixel);
    #1;
    if (m_reading) m_exp_gpu = ref_mem[m_rd_addr];
    if (m_busy > 0) m_busy--;
    else if (m_reading) begin
      m_reading = win_c;
      if (win_c) m_rd_addr = ga_c;
    end else if (win_c) begin
      m_reading = 1'b1;
      m_rd_addr = ga_c;
    end else if (mq.size() > 0 && !soon_c) begin
      m_cur = mq.pop_front();
      m_busy = 3;
      ref_mem[m_cur.a] = m_cur.d;
    end
    if (acc) mq.push_back(send_q.pop_front());
    m_ready_en = 1'b1;
    check("ready", cpu_wr_ready, 32'(m_ready_en && mq.size() < 16));
    check("level", fifo_level, mq.size());
    check("strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe},
          {!(m_reading || m_busy > 0), !m_reading, !(m_busy == 2), m_busy > 0});
    if (m_busy > 0) begin
      check("wr_addr", sram_addr, m_cur.a);
      check("wr_data", sram_dq_out, m_cur.d);
    end
    if (m_reading) check("rd_addr", sram_addr, m_rd_addr);
    check("gpu_data", gpu_data, m_exp_gpu);
    if (h_count == 12'(H_TOTAL - 1)) set_pos(0, (v_count == 12'(V_TOTAL - 1)) ? 0 : v_count + 1);
    else set_pos(h_count + 1, v_count);
    drive_cpu();
    if (rand_gpu) gpu_addr = 17'($urandom);
  endtask

  task automatic drain(input int max_ticks);
    for (int n = 0; n < max_ticks && !model_idle(); n++) tick();
    check("drain_done", model_idle(), 1);
  endtask

  task automatic push_wr(input logic [16:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    send_q.push_back(w);
    drive_cpu();
  endtask

  logic [7:0] t5_data [17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 131072; i++) begin
      sram_mem[i] = 8'(i * 7 + 3);
      ref_mem[i]  = 8'(i * 7 + 3);
    end
    sram_mem[17'h00400] = 8'h3C;
    ref_mem[17'h00400]  = 8'h3C;
    model_reset();
    rand_gpu = 1'b1;
    gpu_using_lb = 1'b0;
    gpu_addr = 17'h00010;
    cpu_wr_addr = '0; cpu_wr_data = '0;
    resetn = 1'b0;

    // Reset held with a CPU request pending and the window open.
    set_pos(300, 100);
    push_wr(17'h0ABCD, 8'h11);
    repeat (3) @(posedge clkPixel);
    #1;
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check("rst_ready", cpu_wr_ready, 0);
    check("rst_level", fifo_level, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_out", sram_dq_out, 0);
    check("rst_gpu_data", gpu_data, 0);
    resetn = 1'b1;
    tick();
    check("rst_release_ready", cpu_wr_ready, 1);
    repeat (3) tick();
    set_pos(10, 10);
    drain(100);

    // Single write in blanking.
    pulse_cnt = 0;
    push_wr(17'h00123, 8'hA5);
    repeat (5) tick();
    check("blank_we_pulses", pulse_cnt, 1);
    check("blank_addr", last_addr, 17'h00123);
    check("blank_data", last_data, 8'hA5);
    drain(50);

    // Write queued two positions before the window must wait for the window to close.
    pulse_cnt = 0;
    set_pos(HS - 2, 100);
    push_wr(17'h02222, 8'h5A);
    tick();
    check("guard_idle_a", sram_dq_oe, 0);
    tick();
    check("guard_idle_b", sram_dq_oe, 0);
    tick();
    check("guard_rd", sram_oe_n, 0);
    for (int i = 0; i < 900 && !(v_count == 12'd101 && h_count == 12'd8); i++) tick();
    check("guard_reach", h_count, 8);
    check("guard_drain_level", fifo_level, 0);
    check("guard_pulses", pulse_cnt, 1);
    check("guard_mem", sram_mem[17'h02222], 8'h5A);

    // Read latency: address at edge k, data after edge k+1, held afterwards.
    set_pos(300, 101);
    rand_gpu = 1'b0;
    gpu_addr = 17'h00400;
    tick();
    tick();
    check("rd_latency", gpu_data, 8'h3C);
    gpu_using_lb = 1'b1;
    rand_gpu = 1'b1;
    repeat (4) tick();
    check("rd_hold", gpu_data, 8'h3C);

    // Seventeen writes inside the window: queue fills at 16, all land in order afterwards.
    gpu_using_lb = 1'b0;
    set_pos(200, 101);
    pulse_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      t5_data[i] = 8'($urandom);
      push_wr((i < 15) ? 17'(17'h01000 + i) : 17'h01010, t5_data[i]);
    end
    repeat (17) tick();
    check("full_level", fifo_level, 16);
    check("full_ready", cpu_wr_ready, 0);
    drain(1200);
    check("full_pulses", pulse_cnt, 17);
    for (int i = 0; i < 15; i++) check("full_mem", sram_mem[17'h01000 + i], t5_data[i]);
    check("full_same_addr_last", sram_mem[17'h01010], t5_data[16]);

    // Line buffer in use: writes drain mid-line and reads never start.
    gpu_using_lb = 1'b1;
    set_pos(300, v_count);
    pulse_cnt = 0;
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) push_wr(17'(17'h03000 + i), 8'(8'hC0 + i));
    repeat (30) tick();
    check("lb_writes", pulse_cnt, 4);
    check("lb_no_read", rd_cycles, 0);
    check("lb_mem", sram_mem[17'h03003], 8'hC3);

    // Random traffic across the first and last active lines.
    for (int seg = 0; seg < 2; seg++) begin
      set_pos(600, (seg == 0) ? VS - 1 : VE - 1);
      for (int n = 0; n < ((seg == 0) ? 2000 : 700); n++) begin
        if (h_count == 12'd0) gpu_using_lb = ($urandom % 3) == 0;
        if (send_q.size() < 2 && ($urandom % 4) == 0) push_wr(17'($urandom), 8'($urandom));
        tick();
      end
    end
    drain(2000);

    // Reset during the write pulse: strobes release at once and the queue is lost.
    gpu_using_lb = 1'b0;
    set_pos(10, 10);
    for (int i = 0; i < 3; i++) push_wr(17'(17'h04000 + i), 8'(8'h70 + i));
    for (int i = 0; i < 10 && m_busy != 2; i++) tick();
    check("midwr_reached", m_busy, 2);
    check("midwr_pulse", sram_we_n, 0);
    #5;
    resetn = 1'b0;
    #1;
    check("midwr_we_n", sram_we_n, 1);
    check("midwr_dq_oe", sram_dq_oe, 0);
    check("midwr_ce_n", sram_ce_n, 1);
    check("midwr_level", fifo_level, 0);
    model_reset();
    drive_cpu();
    @(posedge clkPixel);
    #1;
    resetn = 1'b1;
    repeat (8) tick();
    check("midwr_discard", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
